if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage pipeline; sits directly upstream of the IF/ID pipeline register and drives its addr/inst inputs.
- Owns the PC and runs the instruction-memory request/ready handshake.
- Handles hazard stalls using a one-entry skid buffer.
- Handles branch/jump redirects by squashing any in-flight fetch.

Parameters:
- ADDR_W, 32, PC / memory address width.
- INST_W, 32, instruction width.
- RESET_PC, 0, PC value loaded at reset (low 2 bits must be 0).

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- start_i  in  1  reset: synchronous, active-low. 0 at a rising edge = reset; 1 = run.
- stall_i  in  1  hazard stall from ID: freeze PC and outputs.
- branch_i  in  1  redirect request, one-cycle pulse.
- branch_addr_i  in  ADDR_W  redirect target.
- imem_req_o  out  1  memory request.
- imem_addr_o  out  ADDR_W  memory address.
- imem_ready_i  in  1  memory response valid this cycle.
- imem_data_i  in  INST_W  instruction data; valid when imem_ready_i=1.
- addr_o  out  ADDR_W  PC of delivered instruction, to IF/ID.
- inst_o  out  INST_W  delivered instruction, to IF/ID; 0 = bubble.
- valid_o  out  1  inst_o holds a real instruction.
- fetch_cnt_o  out  32  delivered-instruction count (see Optional Feature).
- bubble_cnt_o  out  32  bubble-cycle count (see Optional Feature).

Behaviour:
- Reset (start_i=0 at edge):
  - pc=RESET_PC, state=IDLE, skid empty, kill=0.
  - addr_o=0, inst_o=0, valid_o=0, counters=0.
  - imem_req_o=0 combinationally while in IDLE.
- Reset mid-operation: any outstanding request is abandoned; memory must tolerate req dropping.
- States:
  - IDLE: first edge with start_i=1 → FETCH.
  - FETCH:
    - imem_req_o=1, imem_addr_o=pc.
    - Request is held, with addr stable, until imem_ready_i=1 at an edge (the accept).
  - KILL:
    - Request already outstanding when a redirect arrived.
    - req/addr held until ready; returned data discarded.
    - Then → FETCH at the new pc.
- Accept in FETCH, stall_i=0, skid empty, branch_i=0:
  - addr_o←pc, inst_o←imem_data_i, valid_o←1.
  - pc←pc+4, modulo 2^ADDR_W.
- Latency: ready-tied-high memory gives 1 instruction/cycle; outputs registered one edge after accept.
- Cycle with no accept and no stall: valid_o←0, inst_o←0 (bubble); addr_o holds.
- stall_i=1:
  - addr_o, inst_o, valid_o and pc hold.
  - An in-flight accept is stored in the skid buffer with its pc; pc←pc+4.
  - imem_req_o=0 while the skid is full.
- Stall release with skid full: skid contents → outputs at the next edge, skid empties, fetching resumes.
- branch_i=1 (priority over stall_i and accept):
  - pc←{branch_addr_i[ADDR_W-1:2],2'b00}; skid cleared.
  - valid_o←0, inst_o←0.
  - If a request is outstanding and imem_ready_i=0 → KILL; else → FETCH.
  - An accept in the same cycle as branch_i is discarded.
- Back-to-back redirects, including while in KILL: the latest target wins; remain in KILL until ready.
- Redirect to the current pc is legal and still squashes.

Optional Feature:
- Macro: IF_PERF_CNT_EN.
- Defined:
  - fetch_cnt_o increments on every edge where valid_o goes or stays 1 with a new instruction.
  - bubble_cnt_o increments on every non-reset edge where valid_o←0.
  - Both wrap at 2^32; both are 0 in reset.
- Undefined: both ports tied to constant 0; no counter flops.

Test Plan:
- Reset then run, ready tied 1, imem_data=addr+0x100 → addr_o=0,4,8,12 on consecutive cycles; inst_o=0x100,0x104,0x108; valid_o=1 from 2nd edge after start_i=1.
- Ready asserted every 3rd cycle → imem_addr_o stable for 3 cycles per fetch; valid_o pattern 0,0,1 repeating; addr_o=0,4,8.
- stall_i high 2 cycles while ready=1 → outputs frozen at addr_o=8; after release addr_o=12 from skid, then 16; no instruction lost or duplicated.
- branch_i to 0x40 while request at 0x10 is waiting (ready low 2 cycles) → data for 0x10 discarded; next valid addr_o=0x40; one or more valid_o=0 bubbles.
- branch_i and stall_i together, target 0x203 → pc=0x200, skid cleared; first delivered addr_o=0x200.
- start_i=0 mid-stream at addr_o=0x24 → next edge all outputs 0, imem_req_o=0; after release, fetch restarts at RESET_PC. With IF_PERF_CNT_EN defined, counters also read 0.

Source files
------------

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs the imem request/ready handshake,
// absorbs hazard stalls in a one-entry skid buffer and squashes fetches on redirect.
// Optional perf counters are enabled by defining IF_PERF_CNT_EN.
module if_fetch_stage #(
   parameter int unsigned       ADDR_W   = 32,
   parameter int unsigned       INST_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk_i,
   input  logic              start_i,
   input  logic              stall_i,
   input  logic              branch_i,
   input  logic [ADDR_W-1:0] branch_addr_i,
   output logic              imem_req_o,
   output logic [ADDR_W-1:0] imem_addr_o,
   input  logic              imem_ready_i,
   input  logic [INST_W-1:0] imem_data_i,
   output logic [ADDR_W-1:0] addr_o,
   output logic [INST_W-1:0] inst_o,
   output logic              valid_o,
   output logic [31:0]       fetch_cnt_o,
   output logic [31:0]       bubble_cnt_o
);

   typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_KILL} state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] kill_addr_q, kill_addr_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [INST_W-1:0] inst_q, inst_d;
   logic              valid_q, valid_d;
   logic              skid_valid_q, skid_valid_d;
   logic [ADDR_W-1:0] skid_addr_q, skid_addr_d;
   logic [INST_W-1:0] skid_inst_q, skid_inst_d;
   logic              accept;
   logic              unused_branch_lsb;

   // Redirect targets are word-aligned; the two low bits are dropped.
   assign unused_branch_lsb = ^branch_addr_i[1:0];

   // While killing, the abandoned request keeps its original address until ready.
   assign imem_req_o  = ((state_q == ST_FETCH) && !skid_valid_q) || (state_q == ST_KILL);
   assign imem_addr_o = (state_q == ST_KILL) ? kill_addr_q : pc_q;
   assign accept      = imem_req_o && imem_ready_i;

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      kill_addr_d  = kill_addr_q;
      addr_d       = addr_q;
      inst_d       = inst_q;
      valid_d      = valid_q;
      skid_valid_d = skid_valid_q;
      skid_addr_d  = skid_addr_q;
      skid_inst_d  = skid_inst_q;
      if (branch_i) begin
         pc_d         = {branch_addr_i[ADDR_W-1:2], 2'b00};
         skid_valid_d = 1'b0;
         valid_d      = 1'b0;
         inst_d       = '0;
         if (imem_req_o && !imem_ready_i) begin
            state_d     = ST_KILL;
            kill_addr_d = imem_addr_o;
         end else begin
            state_d = ST_FETCH;
         end
      end else begin
         if (!stall_i) begin
            valid_d = 1'b0;
            inst_d  = '0;
         end
         case (state_q)
            ST_IDLE: state_d = ST_FETCH;
            ST_FETCH: begin
               if (stall_i) begin
                  if (accept) begin
                     skid_valid_d = 1'b1;
                     skid_addr_d  = pc_q;
                     skid_inst_d  = imem_data_i;
                     pc_d         = pc_q + ADDR_W'(4);
                  end
               end else if (skid_valid_q) begin
                  addr_d       = skid_addr_q;
                  inst_d       = skid_inst_q;
                  valid_d      = 1'b1;
                  skid_valid_d = 1'b0;
               end else if (accept) begin
                  addr_d  = pc_q;
                  inst_d  = imem_data_i;
                  valid_d = 1'b1;
                  pc_d    = pc_q + ADDR_W'(4);
               end
            end
            ST_KILL: if (imem_ready_i) state_d = ST_FETCH;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (!start_i) begin
         state_q      <= ST_IDLE;
         pc_q         <= RESET_PC;
         addr_q       <= '0;
         inst_q       <= '0;
         valid_q      <= 1'b0;
         skid_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         addr_q       <= addr_d;
         inst_q       <= inst_d;
         valid_q      <= valid_d;
         skid_valid_q <= skid_valid_d;
      end
   end

   // NOTE: payload registers need no reset; they are only read when their valid/state qualifier is set.
   always_ff @(posedge clk_i) begin
      kill_addr_q <= kill_addr_d;
      skid_addr_q <= skid_addr_d;
      skid_inst_q <= skid_inst_d;
   end

   assign addr_o  = addr_q;
   assign inst_o  = inst_q;
   assign valid_o = valid_q;

`ifdef IF_PERF_CNT_EN
   logic [31:0] fetch_cnt_q, fetch_cnt_d;
   logic [31:0] bubble_cnt_q, bubble_cnt_d;
   logic        new_inst;

   // A non-stalled edge that leaves valid set always carries a fresh instruction.
   assign new_inst = valid_d && (branch_i || !stall_i);

   always_comb begin
      fetch_cnt_d  = fetch_cnt_q + {31'd0, new_inst};
      bubble_cnt_d = bubble_cnt_q + {31'd0, !valid_d};
   end

   always_ff @(posedge clk_i) begin
      if (!start_i) begin
         fetch_cnt_q  <= '0;
         bubble_cnt_q <= '0;
      end else begin
         fetch_cnt_q  <= fetch_cnt_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign fetch_cnt_o  = fetch_cnt_q;
   assign bubble_cnt_o = bubble_cnt_q;
`else
   assign fetch_cnt_o  = '0;
   assign bubble_cnt_o = '0;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: stimulus pushes expected deliveries,
// a negedge monitor pops and compares every new instruction the stage presents.
module tb_if_fetch_stage;

   logic        clk_i = 1'b0;
   logic        start_i = 1'b0;
   logic        stall_i = 1'b0;
   logic        branch_i = 1'b0;
   logic [31:0] branch_addr_i = '0;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_ready_i = 1'b0;
   logic [31:0] imem_data_i;
   logic [31:0] addr_o;
   logic [31:0] inst_o;
   logic        valid_o;
   logic [31:0] fetch_cnt_o;
   logic [31:0] bubble_cnt_o;

   if_fetch_stage dut (
      .clk_i         (clk_i),
      .start_i       (start_i),
      .stall_i       (stall_i),
      .branch_i      (branch_i),
      .branch_addr_i (branch_addr_i),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_ready_i  (imem_ready_i),
      .imem_data_i   (imem_data_i),
      .addr_o        (addr_o),
      .inst_o        (inst_o),
      .valid_o       (valid_o),
      .fetch_cnt_o   (fetch_cnt_o),
      .bubble_cnt_o  (bubble_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   // Memory returns address + 0x100 as the instruction word.
   assign imem_data_i = imem_addr_o + 32'h100;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] inst;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   function automatic void check(string name, logic [31:0] act, logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
      end
   endfunction

   function automatic void expect_inst(logic [31:0] a, logic [31:0] i);
      exp_q.push_back('{addr: a, inst: i});
   endfunction

   // Monitor: a non-stalled, non-reset edge with valid_o set is a new delivery.
   logic prev_stall = 1'b0;
   logic prev_rst   = 1'b1;
   exp_t mon_e;

   always @(posedge clk_i) begin
      prev_stall <= stall_i;
      prev_rst   <= !start_i;
   end

   always @(negedge clk_i) begin
      if (!prev_rst && !prev_stall) begin
         if (valid_o) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_delivery: got addr 0x%08h, expected none", addr_o);
            end else begin
               mon_e = exp_q.pop_front();
               check("mon_addr_o", addr_o, mon_e.addr);
               check("mon_inst_o", inst_o, mon_e.inst);
            end
         end else begin
            check("mon_bubble_inst", inst_o, 32'h0);
         end
      end
   end

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic reset_dut();
      start_i       = 1'b0;
      stall_i       = 1'b0;
      branch_i      = 1'b0;
      branch_addr_i = '0;
      imem_ready_i  = 1'b0;
      step();
      step();
      check("rst_addr_o", addr_o, 32'h0);
      check("rst_inst_o", inst_o, 32'h0);
      check("rst_valid_o", {31'd0, valid_o}, 32'h0);
      check("rst_imem_req", {31'd0, imem_req_o}, 32'h0);
      check("rst_fetch_cnt", fetch_cnt_o, 32'h0);
      check("rst_bubble_cnt", bubble_cnt_o, 32'h0);
      check("queue_drained", exp_q.size(), 32'h0);
      exp_q.delete();
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Test 1: ready tied high, one instruction per cycle.
      reset_dut();
      expect_inst(32'h0, 32'h100);
      expect_inst(32'h4, 32'h104);
      expect_inst(32'h8, 32'h108);
      expect_inst(32'hC, 32'h10C);
      imem_ready_i = 1'b1;
      start_i      = 1'b1;
      step();
      check("t1_valid_e1", {31'd0, valid_o}, 32'h0);
      check("t1_req_e1", {31'd0, imem_req_o}, 32'h1);
      step();
      check("t1_valid_e2", {31'd0, valid_o}, 32'h1);
      repeat (3) step();

      // Test 2: ready every third cycle.
      reset_dut();
      expect_inst(32'h0, 32'h100);
      expect_inst(32'h4, 32'h104);
      expect_inst(32'h8, 32'h108);
      start_i = 1'b1;
      step();
      for (int k = 0; k < 3; k++) begin
         for (int j = 0; j < 3; j++) begin
            imem_ready_i = (j == 2);
            check("t2_imem_addr", imem_addr_o, 32'(4 * k));
            step();
            check("t2_valid", {31'd0, valid_o}, (j == 2) ? 32'h1 : 32'h0);
         end
      end

      // Test 3: two-cycle stall with ready high, skid absorbs the in-flight fetch.
      reset_dut();
      expect_inst(32'h0,  32'h100);
      expect_inst(32'h4,  32'h104);
      expect_inst(32'h8,  32'h108);
      expect_inst(32'hC,  32'h10C);
      expect_inst(32'h10, 32'h110);
      expect_inst(32'h14, 32'h114);
      imem_ready_i = 1'b1;
      start_i      = 1'b1;
      repeat (4) step();
      check("t3_addr_pre", addr_o, 32'h8);
      stall_i = 1'b1;
      step();
      check("t3_addr_stall1", addr_o, 32'h8);
      check("t3_valid_stall1", {31'd0, valid_o}, 32'h1);
      check("t3_req_skid_full", {31'd0, imem_req_o}, 32'h0);
      step();
      check("t3_addr_stall2", addr_o, 32'h8);
      check("t3_inst_stall2", inst_o, 32'h108);
      stall_i = 1'b0;
      step();
      check("t3_addr_from_skid", addr_o, 32'hC);
      repeat (2) step();

      // Test 4: redirect while a request at 0x10 is waiting.
      reset_dut();
      expect_inst(32'h0,  32'h100);
      expect_inst(32'h4,  32'h104);
      expect_inst(32'h8,  32'h108);
      expect_inst(32'hC,  32'h10C);
      expect_inst(32'h40, 32'h140);
      expect_inst(32'h44, 32'h144);
      imem_ready_i = 1'b1;
      start_i      = 1'b1;
      repeat (5) step();
      imem_ready_i = 1'b0;
      step();
      check("t4_imem_addr_wait", imem_addr_o, 32'h10);
      branch_i      = 1'b1;
      branch_addr_i = 32'h40;
      step();
      branch_i = 1'b0;
      check("t4_kill_addr_held", imem_addr_o, 32'h10);
      check("t4_kill_req", {31'd0, imem_req_o}, 32'h1);
      check("t4_kill_valid", {31'd0, valid_o}, 32'h0);
      imem_ready_i = 1'b1;
      step();
      check("t4_refetch_addr", imem_addr_o, 32'h40);
      check("t4_discard_valid", {31'd0, valid_o}, 32'h0);
      repeat (2) step();

      // Test 5: branch and stall together with an unaligned target.
      reset_dut();
      expect_inst(32'h0,   32'h100);
      expect_inst(32'h4,   32'h104);
      expect_inst(32'h200, 32'h300);
      expect_inst(32'h204, 32'h304);
      imem_ready_i = 1'b1;
      start_i      = 1'b1;
      repeat (3) step();
      stall_i = 1'b1;
      step();
      check("t5_req_skid_full", {31'd0, imem_req_o}, 32'h0);
      branch_i      = 1'b1;
      branch_addr_i = 32'h203;
      step();
      branch_i = 1'b0;
      stall_i  = 1'b0;
      check("t5_valid_squash", {31'd0, valid_o}, 32'h0);
      check("t5_inst_squash", inst_o, 32'h0);
      check("t5_pc_aligned", imem_addr_o, 32'h200);
      check("t5_req_resume", {31'd0, imem_req_o}, 32'h1);
      repeat (2) step();

      // Test 6: reset mid-stream, then restart at RESET_PC.
      reset_dut();
      for (int i = 0; i < 10; i++) expect_inst(32'(4 * i), 32'(4 * i + 32'h100));
      imem_ready_i = 1'b1;
      start_i      = 1'b1;
      repeat (11) step();
      check("t6_addr_pre", addr_o, 32'h24);
`ifdef IF_PERF_CNT_EN
      check("t6_fetch_cnt", fetch_cnt_o, 32'd10);
      check("t6_bubble_cnt", bubble_cnt_o, 32'd1);
`else
      check("t6_fetch_cnt_tied", fetch_cnt_o, 32'd0);
      check("t6_bubble_cnt_tied", bubble_cnt_o, 32'd0);
`endif
      start_i = 1'b0;
      step();
      check("t6_rst_addr_o", addr_o, 32'h0);
      check("t6_rst_inst_o", inst_o, 32'h0);
      check("t6_rst_valid_o", {31'd0, valid_o}, 32'h0);
      check("t6_rst_req", {31'd0, imem_req_o}, 32'h0);
      check("t6_rst_fetch_cnt", fetch_cnt_o, 32'h0);
      check("t6_rst_bubble_cnt", bubble_cnt_o, 32'h0);
      expect_inst(32'h0, 32'h100);
      start_i = 1'b1;
      step();
      check("t6_restart_addr", imem_addr_o, 32'h0);
      check("t6_restart_req", {31'd0, imem_req_o}, 32'h1);
      step();

      reset_dut();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
